// File: rtl/mult_div_seq.sv
// -----------------------------------------------------------------------------
// mult_div_seq
//   Iterative signed multiply/divide unit for the multicycle MIPS datapath
//   (MULT, DIV). It holds the HI/LO result registers that the write-back mux
//   reads for MFHI/MFLO. The control FSM pulses start, then stalls until done.
//
//   Configuration macro: DIV_EN
//     defined   : full MULT + DIV (restoring divider on magnitudes, sign fix)
//     undefined : divider datapath not built; an op=1 request completes at
//                 edge 1 with hi/lo unchanged and div_zero=0.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous reset, active-low
//   start      in   1      request, sampled only in IDLE
//   op         in   1      0 = signed MULT, 1 = signed DIV
//   operand_a  in   WIDTH  multiplicand / dividend (rs)
//   operand_b  in   WIDTH  multiplier / divisor (rt)
//   busy       out  1      high while the FSM is not IDLE
//   done       out  1      one-cycle pulse; hi/lo valid from this cycle
//   div_zero   out  1      high in the done cycle of a DIV by zero
//   hi         out  WIDTH  MULT: product[2W-1:W]; DIV: remainder
//   lo         out  WIDTH  MULT: product[W-1:0];  DIV: quotient
// -----------------------------------------------------------------------------
module mult_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    // Shared work registers. MULT: acc_hi = Booth A (one guard bit so that
    // subtracting the most negative multiplicand cannot overflow), acc_lo = Q.
    // DIV: acc_hi = partial remainder, acc_lo = dividend shifting into quotient.
    logic [WIDTH:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic             q_m1_q, q_m1_d;
    logic [WIDTH:0]   m_q, m_d;
    logic             op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             skip_q, skip_d;      // FINISH must not touch hi/lo
    logic             zero_q, zero_d;      // pending divide-by-zero flag
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;
    logic [WIDTH:0]   booth_sum;
`ifdef DIV_EN
    logic             quo_neg_q, quo_neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;            // MSB is the borrow of the trial subtract
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            q_m1_q    <= 1'b0;
            m_q       <= '0;
            op_q      <= 1'b0;
            cnt_q     <= '0;
            skip_q    <= 1'b0;
            zero_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
`ifdef DIV_EN
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            q_m1_q    <= q_m1_d;
            m_q       <= m_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            skip_q    <= skip_d;
            zero_q    <= zero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
`ifdef DIV_EN
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        q_m1_d   = q_m1_q;
        m_d      = m_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        skip_d   = skip_q;
        zero_d   = zero_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dz_d     = 1'b0;

        // Booth recoding of {Q[0], Q[-1]}: 01 adds M, 10 subtracts M.
        case ({acc_lo_q[0], q_m1_q})
            2'b01:   booth_sum = acc_hi_q + m_q;
            2'b10:   booth_sum = acc_hi_q - m_q;
            default: booth_sum = acc_hi_q;
        endcase

`ifdef DIV_EN
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        abs_a     = operand_a[WIDTH-1] ? -operand_a : operand_a;
        abs_b     = operand_b[WIDTH-1] ? -operand_b : operand_b;
        div_shift = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {1'b0, m_q};
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d   = op;
                    cnt_d  = '0;
                    q_m1_d = 1'b0;
                    skip_d = 1'b0;
                    zero_d = 1'b0;
                    if (!op) begin
                        acc_hi_d = '0;
                        acc_lo_d = operand_b;
                        m_d      = {operand_a[WIDTH-1], operand_a};
                        state_d  = S_CALC;
                    end else begin
`ifdef DIV_EN
                        if (operand_b == '0) begin
                            skip_d  = 1'b1;
                            zero_d  = 1'b1;
                            state_d = S_FINISH;
                        end else begin
                            acc_hi_d  = '0;
                            acc_lo_d  = abs_a;
                            m_d       = {1'b0, abs_b};
                            quo_neg_d = operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                            rem_neg_d = operand_a[WIDTH-1];
                            state_d   = S_CALC;
                        end
`else
                        // No divider: complete immediately without a result.
                        skip_d  = 1'b1;
                        state_d = S_FINISH;
`endif
                    end
                end
            end

            S_CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_FINISH;
                end
`ifdef DIV_EN
                if (op_q) begin
                    // Restoring step: keep the trial difference only if no borrow.
                    if (!div_diff[WIDTH+1]) begin
                        acc_hi_d = div_diff[WIDTH:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi_d = div_shift;
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
                    end
                end else
`endif
                begin
                    // Arithmetic shift right of {A, Q, Q[-1]}.
                    acc_hi_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                    acc_lo_d = {booth_sum[0], acc_lo_q[WIDTH-1:1]};
                    q_m1_d   = acc_lo_q[0];
                end
            end

            S_FINISH: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                dz_d    = zero_q;
                if (!skip_q) begin
`ifdef DIV_EN
                    if (op_q) begin
                        lo_d = quo_neg_q ? -acc_lo_q : acc_lo_q;
                        hi_d = rem_neg_q ? -acc_hi_q[WIDTH-1:0] : acc_hi_q[WIDTH-1:0];
                    end else
`endif
                    begin
                        hi_d = acc_hi_q[WIDTH-1:0];
                        lo_d = acc_lo_q;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_seq.sv
module tb_mult_div_seq;
    localparam int W = 32;
`ifdef DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         op;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    always #5 clk = ~clk;

    mult_div_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .hi        (hi),
        .lo        (lo)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           lat;
    } exp_t;

    typedef struct {
        logic         op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    exp_t         sb[$];
    logic [W-1:0] model_hi = '0;
    logic [W-1:0] model_lo = '0;
    vec_t         vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Drive a request and push its expected outcome. Requests that complete
    // without a result (divide by zero, or DIV without a divider) keep hi/lo.
    task automatic launch(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] rhi, input logic [W-1:0] rlo);
        exp_t e;
        start     = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        if (o && (!DIV_ON || b == '0)) begin
            e.hi  = model_hi;
            e.lo  = model_lo;
            e.dz  = DIV_ON && (b == '0);
            e.lat = 1;
        end else begin
            e.hi  = rhi;
            e.lo  = rlo;
            e.dz  = 1'b0;
            e.lat = W + 1;
        end
        sb.push_back(e);
    endtask

    // Called after edge k0 of the current operation; waits for done.
    task automatic wait_done(input string name, input int k0);
        exp_t e;
        int   k;
        bit   seen;
        bit   busy_ok;
        e       = sb.pop_front();
        seen    = 1'b0;
        busy_ok = 1'b1;
        for (k = k0 + 1; k <= W + 8; k++) begin
            step;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got no done expected done by edge %0d", name, e.lat);
            return;
        end
        chk($sformatf("%s_latency", name), 64'(k), 64'(e.lat));
        chk($sformatf("%s_busy_during", name), 64'(busy_ok), 64'd1);
        chk($sformatf("%s_busy_at_done", name), 64'(busy), 64'd0);
        chk($sformatf("%s_hi", name), 64'(hi), 64'(e.hi));
        chk($sformatf("%s_lo", name), 64'(lo), 64'(e.lo));
        chk($sformatf("%s_div_zero", name), 64'(div_zero), 64'(e.dz));
        model_hi = e.hi;
        model_lo = e.lo;
        $display("txn %s op=%0d a=%08h b=%08h -> hi=%08h lo=%08h dz=%0d edge=%0d",
                 name, op, operand_a, operand_b, hi, lo, div_zero, k);
    endtask

    task automatic run_vec(input string name, input vec_t v);
        launch(v.op, v.a, v.b, v.hi, v.lo);
        step;                                   // edge 0
        start = 1'b0;
        chk($sformatf("%s_busy_edge0", name), 64'(busy), 64'd1);
        wait_done(name, 0);
        step;                                   // cycle after done
        chk($sformatf("%s_done_pulse", name), 64'({done, div_zero}), 64'd0);
        chk($sformatf("%s_hold", name), {hi, lo}, {model_hi, model_lo});
    endtask

    initial begin
        vec_t v;
        int   ndone;
        longint p;

        vecs[0]  = '{1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1]  = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[2]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[3]  = '{1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000};
        vecs[4]  = '{1'b0, 32'h0001_2345, 32'h0001_0000, 32'h0000_0001, 32'h2345_0000};
        vecs[5]  = '{1'b1, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        vecs[6]  = '{1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[7]  = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[8]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[9]  = '{1'b1, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
        vecs[10] = '{1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_000E};
        vecs[11] = '{1'b0, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000};

        rst_n     = 1'b0;
        start     = 1'b0;
        op        = 1'b0;
        operand_a = '0;
        operand_b = '0;
        step;
        step;
        chk("reset_outputs", {31'd0, busy, done, div_zero, hi, lo}, 64'd0);
        rst_n = 1'b1;
        step;

        for (int i = 0; i < 12; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        for (int i = 0; i < 6; i++) begin
            v.op = 1'b0;
            v.a  = $urandom;
            v.b  = $urandom;
            p    = longint'($signed(v.a)) * longint'($signed(v.b));
            v.hi = p[63:32];
            v.lo = p[31:0];
            run_vec($sformatf("rand%0d", i), v);
        end

        // Back-to-back: a new start is accepted in the done cycle.
        launch(1'b0, 32'h0000_0003, 32'h0000_0005, 32'h0, 32'h0000_000F);
        step;
        start = 1'b0;
        wait_done("b2b_first", 0);
        launch(1'b0, 32'hFFFF_FFFE, 32'h0000_0009, 32'hFFFF_FFFF, 32'hFFFF_FFEE);
        step;
        start = 1'b0;
        chk("b2b_busy_edge0", 64'(busy), 64'd1);
        wait_done("b2b_second", 0);

        // A start while busy and later operand changes are ignored.
        launch(1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        step;
        start = 1'b0;
        repeat (4) step;
        start     = 1'b1;
        op        = 1'b1;
        operand_a = 32'h0000_0100;
        operand_b = 32'h0000_0000;
        step;                                   // edge 5
        start     = 1'b0;
        operand_a = 32'hDEAD_BEEF;
        wait_done("ignored_start", 5);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            step;
            if (done) ndone++;
        end
        chk("ignored_start_no_extra_done", 64'(ndone), 64'd0);

        // Reset mid-operation: outputs clear at once and no done follows.
        launch(1'b0, 32'h0000_0005, 32'h0000_0006, 32'h0, 32'h0000_001E);
        step;
        start = 1'b0;
        repeat (4) step;
        start     = 1'b1;
        operand_a = 32'h0000_0011;
        operand_b = 32'h0000_0022;
        step;                                   // edge 5
        start = 1'b0;
        repeat (4) step;
        rst_n = 1'b0;
        #1;
        chk("abort_hi_lo", {hi, lo}, 64'd0);
        chk("abort_flags", 64'({busy, done, div_zero}), 64'd0);
        sb.delete();
        model_hi = '0;
        model_lo = '0;
        step;
        step;
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            step;
            if (done || busy) ndone++;
        end
        chk("abort_no_done", 64'(ndone), 64'd0);

        v = '{1'b0, 32'hFFFF_FFF0, 32'h0000_0010, 32'hFFFF_FFFF, 32'hFFFF_FF00};
        run_vec("after_reset", v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
